program_loader: RTL and testbench

//  Writer side of instruction fetch: fills the writable instruction memory that the MiniAlu core reads at wIP.

---
 rtl/program_loader.sv | 202 ++++++++++++++++++++
 tb/tb_program_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
// Writer side of instruction fetch. Receives a framed byte stream
// (LEN_LO, LEN_HI, 4*LEN payload bytes, CHK), packs every four payload
// bytes into one instruction word, and writes the words to instruction
// memory starting at address 0. The core is held in reset for the whole
// load and is released only after the checksum byte matches.
module program_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int INST_WIDTH = 28,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iStart,
    input  logic [7:0]            iByte,
    input  logic                  iByteValid,
    output logic                  oByteReady,
    output logic                  oWriteEnable,
    output logic [ADDR_WIDTH-1:0] oWriteAddress,
    output logic [INST_WIDTH-1:0] oWriteData,
    output logic                  oCpuReset,
    output logic                  oDone,
    output logic                  oError
);

    // Width wide enough to compare the word index against any 16-bit LEN
    // and against MAX_WORDS without truncation.
    localparam int CW = ((ADDR_WIDTH > 16) ? ADDR_WIDTH : 16) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } LoaderState;

    LoaderState state;
    LoaderState nextState;

    logic [15:0]           wordLength;
    logic [ADDR_WIDTH-1:0] wordIndex;
    logic [1:0]            byteIndex;
    logic [7:0]            checksum;
    logic [INST_WIDTH-1:0] wordBuffer;

    logic        byteAccept;
    logic        armLoad;
    logic [15:0] lengthCandidate;
    logic        lengthZero;
    logic        lengthTooBig;
    logic        lastWord;

    // Handshake, re-arm qualification and LEN/word-count decisions shared by
    // the next-state logic and the datapath.
    always_comb begin
        byteAccept      = iByteValid & oByteReady;
        armLoad         = iStart & ((state == IDLE) || (state == DONE) || (state == ERROR));
        lengthCandidate = {iByte, wordLength[7:0]};
        lengthZero      = (lengthCandidate == 16'd0);
        lengthTooBig    = (CW'(lengthCandidate) > CW'(MAX_WORDS));
        lastWord        = ((CW'(wordIndex) + CW'(1)) == CW'(wordLength));
    end

    // State register; reset abandons any frame in progress.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode for the frame parser.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (armLoad) nextState = LEN_LO;
            end
            LEN_LO: begin
                if (byteAccept) nextState = LEN_HI;
            end
            LEN_HI: begin
                if (byteAccept) begin
                    if (lengthZero)        nextState = CHECK;
                    else if (lengthTooBig) nextState = ERROR;
                    else                   nextState = DATA;
                end
            end
            DATA: begin
                if (byteAccept && (byteIndex == 2'd3)) nextState = WRITE;
            end
            WRITE: begin
                if (lastWord) nextState = CHECK;
                else          nextState = DATA;
            end
            CHECK: begin
                if (byteAccept) begin
                    if (iByte == checksum) nextState = DONE;
                    else                   nextState = ERROR;
                end
            end
            DONE: begin
                if (armLoad) nextState = LEN_LO;
            end
            ERROR: begin
                if (armLoad) nextState = LEN_LO;
            end
            default: nextState = IDLE;
        endcase
    end

    // Moore outputs: ready while a byte is expected, one-cycle write strobe,
    // core released only in DONE.
    always_comb begin
        oByteReady    = 1'b0;
        oWriteEnable  = 1'b0;
        oWriteAddress = '0;
        oWriteData    = '0;
        oCpuReset     = 1'b1;
        oDone         = 1'b0;
        oError        = 1'b0;
        case (state)
            LEN_LO, LEN_HI, DATA, CHECK: begin
                oByteReady = 1'b1;
            end
            WRITE: begin
                oWriteEnable  = 1'b1;
                oWriteAddress = wordIndex;
                oWriteData    = wordBuffer;
            end
            DONE: begin
                oDone     = 1'b1;
                oCpuReset = 1'b0;
            end
            ERROR: begin
                oError = 1'b1;
            end
            default: begin
                oByteReady = 1'b0;
            end
        endcase
    end

    // Datapath: length capture, byte packing, word counting and the running
    // XOR checksum over LEN and payload bytes (the CHK byte is not folded in).
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wordLength <= '0;
            wordIndex  <= '0;
            byteIndex  <= '0;
            checksum   <= '0;
            wordBuffer <= '0;
        end else if (armLoad) begin
            wordLength <= '0;
            wordIndex  <= '0;
            byteIndex  <= '0;
            checksum   <= '0;
            wordBuffer <= '0;
        end else begin
            case (state)
                LEN_LO: begin
                    if (byteAccept) begin
                        wordLength[7:0] <= iByte;
                        checksum        <= checksum ^ iByte;
                    end
                end
                LEN_HI: begin
                    if (byteAccept) begin
                        wordLength[15:8] <= iByte;
                        checksum         <= checksum ^ iByte;
                    end
                end
                DATA: begin
                    if (byteAccept) begin
                        checksum  <= checksum ^ iByte;
                        byteIndex <= byteIndex + 2'd1;
                        case (byteIndex)
                            2'd0: wordBuffer[7:0]   <= iByte;
                            2'd1: wordBuffer[15:8]  <= iByte;
                            2'd2: wordBuffer[23:16] <= iByte;
                            default: wordBuffer[INST_WIDTH-1:24] <= iByte[INST_WIDTH-25:0];
                        endcase
                    end
                end
                WRITE: begin
                    wordIndex  <= wordIndex + ADDR_WIDTH'(1);
                    byteIndex  <= '0;
                    wordBuffer <= '0;
                end
                default: begin
                    wordIndex <= wordIndex;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: frames are pushed through the byte
// handshake and the resulting memory writes, status levels and core reset
// are compared against hand-computed values.
module tb_program_loader;

    logic        Clock;
    logic        Reset;
    logic        iStart;
    logic [7:0]  iByte;
    logic        iByteValid;
    logic        oByteReady;
    logic        oWriteEnable;
    logic [15:0] oWriteAddress;
    logic [27:0] oWriteData;
    logic        oCpuReset;
    logic        oDone;
    logic        oError;

    int assertCount = 0;
    int failCount   = 0;
    int writeCount  = 0;
    int base;

    logic [15:0] wrAddr [0:63];
    logic [27:0] wrData [0:63];

    program_loader #(
        .ADDR_WIDTH(16),
        .INST_WIDTH(28),
        .MAX_WORDS (256)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iStart       (iStart),
        .iByte        (iByte),
        .iByteValid   (iByteValid),
        .oByteReady   (oByteReady),
        .oWriteEnable (oWriteEnable),
        .oWriteAddress(oWriteAddress),
        .oWriteData   (oWriteData),
        .oCpuReset    (oCpuReset),
        .oDone        (oDone),
        .oError       (oError)
    );

    // Free-running clock, 10 time units per period.
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Record every cycle the write strobe is high, so a strobe that lasts
    // longer than one cycle shows up as an extra write.
    always @(negedge Clock) begin
        if (oWriteEnable === 1'b1 && writeCount < 64) begin
            wrAddr[writeCount] <= oWriteAddress;
            wrData[writeCount] <= oWriteData;
        end
        if (oWriteEnable === 1'b1) writeCount <= writeCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offer one byte, optionally after random idle gaps, and hold it until
    // the loader accepts it on a rising edge.
    task automatic applyStimulus(input logic [7:0] b, input int gapPct);
        int waited;
        for (int g = 0; g < 4 && ($urandom_range(99) < gapPct); g++) begin
            @(negedge Clock);
            iByteValid = 1'b0;
        end
        @(negedge Clock);
        iByte      = b;
        iByteValid = 1'b1;
        waited     = 0;
        while (oByteReady !== 1'b1 && waited < 20) begin
            @(negedge Clock);
            waited++;
        end
        checkOutput("byteAccepted", {31'd0, oByteReady}, 32'd1);
        if (oByteReady === 1'b1) begin
            @(posedge Clock);
            #1;
        end else begin
            iByteValid = 1'b0;
        end
    endtask

    task automatic endFrame();
        @(negedge Clock);
        iByteValid = 1'b0;
    endtask

    task automatic pulseStart();
        @(negedge Clock);
        iStart = 1'b1;
        @(negedge Clock);
        iStart = 1'b0;
    endtask

    // Two-word reference frame; checksum of its LEN and payload bytes is 0x02.
    task automatic sendReferenceFrame(input logic [7:0] chk, input int gapPct);
        logic [7:0] frame [0:9];
        frame = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h01, 8'h03, 8'h05, 8'h04, 8'h00, 8'h02};
        for (int i = 0; i < 10; i++) applyStimulus(frame[i], gapPct);
        applyStimulus(chk, gapPct);
        endFrame();
    endtask

    task automatic checkReferenceImage(input string tag, input int first);
        checkOutput({tag, "_count"}, writeCount - first, 2);
        checkOutput({tag, "_addr0"}, {16'd0, wrAddr[first]}, 32'h0);
        checkOutput({tag, "_data0"}, {4'd0, wrData[first]}, 32'h3010001);
        checkOutput({tag, "_addr1"}, {16'd0, wrAddr[first+1]}, 32'h1);
        checkOutput({tag, "_data1"}, {4'd0, wrData[first+1]}, 32'h2000405);
    endtask

    initial begin
        Reset      = 1'b1;
        iStart     = 1'b0;
        iByte      = 8'h00;
        iByteValid = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);

        // Reset state
        checkOutput("rst_cpuReset", {31'd0, oCpuReset}, 32'd1);
        checkOutput("rst_ready", {31'd0, oByteReady}, 32'd0);
        checkOutput("rst_we", {31'd0, oWriteEnable}, 32'd0);
        checkOutput("rst_done", {31'd0, oDone}, 32'd0);
        checkOutput("rst_error", {31'd0, oError}, 32'd0);
        checkOutput("rst_addr", {16'd0, oWriteAddress}, 32'd0);
        checkOutput("rst_data", {4'd0, oWriteData}, 32'd0);

        // Test 1: good two-word frame, with write latency checked on word 0
        base = writeCount;
        pulseStart();
        checkOutput("t1_readyLenLo", {31'd0, oByteReady}, 32'd1);
        checkOutput("t1_cpuResetLoad", {31'd0, oCpuReset}, 32'd1);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h03, 0);
        @(negedge Clock);
        checkOutput("t1_strobe", {31'd0, oWriteEnable}, 32'd1);
        checkOutput("t1_strobeAddr", {16'd0, oWriteAddress}, 32'd0);
        checkOutput("t1_strobeData", {4'd0, oWriteData}, 32'h3010001);
        checkOutput("t1_readyInWrite", {31'd0, oByteReady}, 32'd0);
        applyStimulus(8'h05, 0);
        applyStimulus(8'h04, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h02, 0);
        endFrame();
        checkOutput("t1_done", {31'd0, oDone}, 32'd1);
        checkOutput("t1_cpuReset", {31'd0, oCpuReset}, 32'd0);
        checkOutput("t1_error", {31'd0, oError}, 32'd0);
        checkOutput("t1_readyDone", {31'd0, oByteReady}, 32'd0);
        checkReferenceImage("t1", base);

        // Test 2: same frame, bad checksum
        base = writeCount;
        pulseStart();
        checkOutput("t2_doneCleared", {31'd0, oDone}, 32'd0);
        checkOutput("t2_cpuResetArm", {31'd0, oCpuReset}, 32'd1);
        sendReferenceFrame(8'hFF, 0);
        checkOutput("t2_error", {31'd0, oError}, 32'd1);
        checkOutput("t2_done", {31'd0, oDone}, 32'd0);
        checkOutput("t2_cpuReset", {31'd0, oCpuReset}, 32'd1);
        checkReferenceImage("t2", base);

        // Test 3: empty program, good then bad checksum
        base = writeCount;
        pulseStart();
        checkOutput("t3_errorCleared", {31'd0, oError}, 32'd0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        endFrame();
        checkOutput("t3_done", {31'd0, oDone}, 32'd1);
        checkOutput("t3_noWrite", writeCount - base, 32'd0);
        pulseStart();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        endFrame();
        checkOutput("t3_error", {31'd0, oError}, 32'd1);
        checkOutput("t3_doneLow", {31'd0, oDone}, 32'd0);

        // Test 4: LEN above the limit, then a good reload
        base = writeCount;
        pulseStart();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h01, 0);
        endFrame();
        checkOutput("t4_error", {31'd0, oError}, 32'd1);
        checkOutput("t4_ready", {31'd0, oByteReady}, 32'd0);
        checkOutput("t4_noWrite", writeCount - base, 32'd0);
        pulseStart();
        sendReferenceFrame(8'h02, 0);
        checkOutput("t4_done", {31'd0, oDone}, 32'd1);
        checkReferenceImage("t4", base);

        // Test 5: random valid gaps
        base = writeCount;
        pulseStart();
        sendReferenceFrame(8'h02, 50);
        checkOutput("t5_done", {31'd0, oDone}, 32'd1);
        checkOutput("t5_cpuReset", {31'd0, oCpuReset}, 32'd0);
        checkReferenceImage("t5", base);

        // Test 6: reset in the middle of the first word, then a clean load
        base = writeCount;
        pulseStart();
        applyStimulus(8'h02, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        @(negedge Clock);
        iByteValid = 1'b0;
        Reset      = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        checkOutput("t6_ready", {31'd0, oByteReady}, 32'd0);
        checkOutput("t6_cpuReset", {31'd0, oCpuReset}, 32'd1);
        checkOutput("t6_done", {31'd0, oDone}, 32'd0);
        repeat (4) @(negedge Clock);
        checkOutput("t6_noWrite", writeCount - base, 32'd0);
        checkOutput("t6_idleReady", {31'd0, oByteReady}, 32'd0);
        pulseStart();
        sendReferenceFrame(8'h02, 0);
        checkOutput("t6_done2", {31'd0, oDone}, 32'd1);
        checkReferenceImage("t6", base);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Hard stop in case the stimulus sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
